// File: rtl/data_offload_buffer_core.sv
// -----------------------------------------------------------------------------
// data_offload_buffer_core
//
// Captures a burst from a write-side AXI-Stream into an inferred block RAM and
// plays it back on a read-side AXI-Stream, either once or cyclically,
// optionally gated by a rising edge of an external sync trigger.
//
// Ports
//   clk, rst                       single clock, asynchronous active-high reset
//   s_axis_valid/ready/last/data   capture stream (ready only while in WRITE)
//   m_axis_valid/ready/last/data   playback stream (all outputs registered)
//   init_req                       level request to (re)capture a buffer
//   sync_ext                       external playback trigger (rising edge)
//   oneshot                        1 = single pass, 0 = cyclic playback
//   sync_mode                      1 = wait for sync_ext rising edge
//   transfer_length                capture limit in beats, 0 = full depth
//   stored_len                     number of beats captured
//   state                          IDLE=0, WRITE=1, WAIT_SYNC=2, READ=3
//   overflow                       capture was cut by the limit, not by last
// -----------------------------------------------------------------------------
module data_offload_buffer_core #(
   parameter int DATA_WIDTH     = 64,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter bit HAS_SYNC       = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_axis_valid,
   output logic                      s_axis_ready,
   input  logic                      s_axis_last,
   input  logic [DATA_WIDTH-1:0]     s_axis_data,
   output logic                      m_axis_valid,
   input  logic                      m_axis_ready,
   output logic                      m_axis_last,
   output logic [DATA_WIDTH-1:0]     m_axis_data,
   input  logic                      init_req,
   input  logic                      sync_ext,
   input  logic                      oneshot,
   input  logic                      sync_mode,
   input  logic [MEM_ADDR_WIDTH:0]   transfer_length,
   output logic [MEM_ADDR_WIDTH:0]   stored_len,
   output logic [1:0]                state,
   output logic                      overflow
);

   localparam int DEPTH = 2**MEM_ADDR_WIDTH;
   localparam logic [MEM_ADDR_WIDTH:0] DEPTH_L = (MEM_ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_WAIT_SYNC = 2'd2,
      ST_READ      = 2'd3
   } state_t;

   state_t state_reg, state_next;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    init_prev_reg, sync_prev_reg;
   logic                    oneshot_reg, abort_reg, fetch_done_reg;
   logic [MEM_ADDR_WIDTH:0] wr_cnt_reg, stored_len_reg;
   logic                    overflow_reg;
   logic [MEM_ADDR_WIDTH-1:0] rd_addr_reg;

   // read pipeline: RAM output stage (p), skid stage and output stage
   logic [DATA_WIDTH-1:0]   mem_q_reg;
   logic                    p_valid_reg, p_last_reg;
   logic [DATA_WIDTH-1:0]   skid_data_reg, out_data_reg;
   logic                    skid_valid_reg, skid_last_reg;
   logic                    out_valid_reg, out_last_reg;

   logic                    init_rise, sync_rise, sync_on;
   logic [MEM_ADDR_WIDTH:0] limit, wr_cnt_inc;
   logic                    wr_fire, wr_end;
   logic                    pop, load_out, ws_go, rd_abort, rd_leave_abort, rd_done;
   logic                    rd_en, rd_room, rd_is_last;
   logic [1:0]              occ;

   assign init_rise  = init_req & ~init_prev_reg;
   assign sync_rise  = sync_ext & ~sync_prev_reg;
   assign sync_on    = HAS_SYNC & sync_mode;

   // limits of 0 or above the RAM size both mean "fill the whole RAM"
   assign limit      = (transfer_length == '0 || transfer_length > DEPTH_L) ? DEPTH_L : transfer_length;
   assign wr_fire    = s_axis_valid & (state_reg == ST_WRITE);
   assign wr_cnt_inc = wr_cnt_reg + 1'b1;
   assign wr_end     = wr_fire & (s_axis_last | (wr_cnt_inc == limit));

   assign pop        = out_valid_reg & m_axis_ready;
   assign load_out   = pop | ~out_valid_reg;
   assign ws_go      = (state_reg == ST_WAIT_SYNC) & ~init_rise & (~sync_on | sync_rise);
   assign rd_abort   = init_rise | abort_reg;
   // a re-init waits until the beat on the output has been taken
   assign rd_leave_abort = (state_reg == ST_READ) & rd_abort & load_out;
   assign rd_done    = (state_reg == ST_READ) & pop & out_last_reg & oneshot_reg;

   // Fetch only when the beat will have a slot: at most two beats may be held
   // in skid + output once the in-flight RAM read lands.
   assign occ        = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, p_valid_reg};
   assign rd_room    = (occ < 2'd2) | (pop & (occ == 2'd2));
   // Fetching starts in the WAIT_SYNC cycle that decides to play, saving a cycle
   assign rd_en      = rd_room & (ws_go |
                       ((state_reg == ST_READ) & ~rd_abort & ~fetch_done_reg));
   assign rd_is_last = ({1'b0, rd_addr_reg} == (stored_len_reg - 1'b1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:      if (init_req) state_next = ST_WRITE;
         ST_WRITE:     if (wr_end) state_next = ST_WAIT_SYNC;
         ST_WAIT_SYNC: begin
            if (init_rise)  state_next = ST_WRITE;
            else if (ws_go) state_next = ST_READ;
         end
         ST_READ: begin
            if (rd_leave_abort) state_next = ST_WRITE;
            else if (rd_done)   state_next = ST_IDLE;
         end
         default:      state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // RAM: write port in WRITE, registered read port in WAIT_SYNC/READ
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_cnt_reg[MEM_ADDR_WIDTH-1:0]] <= s_axis_data;
      if (rd_en)   mem_q_reg <= mem[rd_addr_reg];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_prev_reg  <= 1'b0;
         sync_prev_reg  <= 1'b0;
         oneshot_reg    <= 1'b0;
         abort_reg      <= 1'b0;
         fetch_done_reg <= 1'b0;
         wr_cnt_reg     <= '0;
         stored_len_reg <= '0;
         overflow_reg   <= 1'b0;
         rd_addr_reg    <= '0;
         p_valid_reg    <= 1'b0;
         p_last_reg     <= 1'b0;
         skid_valid_reg <= 1'b0;
         skid_last_reg  <= 1'b0;
         skid_data_reg  <= '0;
         out_valid_reg  <= 1'b0;
         out_last_reg   <= 1'b0;
         out_data_reg   <= '0;
      end else begin
         init_prev_reg <= init_req;
         sync_prev_reg <= sync_ext;

         // capture side
         if (state_reg != ST_WRITE && state_next == ST_WRITE) begin
            wr_cnt_reg   <= '0;
            overflow_reg <= 1'b0;
         end else if (wr_fire) begin
            wr_cnt_reg <= wr_cnt_inc;
            if (wr_end) begin
               stored_len_reg <= wr_cnt_inc;
               overflow_reg   <= ~s_axis_last;
               oneshot_reg    <= oneshot;
            end
         end

         // re-init request remembered until the held beat is accepted
         if (state_reg != ST_READ || rd_leave_abort) abort_reg <= 1'b0;
         else if (init_rise)                         abort_reg <= 1'b1;

         // fetch address generation
         if (rd_en) begin
            rd_addr_reg    <= rd_is_last ? '0 : rd_addr_reg + 1'b1;
            fetch_done_reg <= oneshot_reg & rd_is_last;
            p_last_reg     <= rd_is_last;
         end else if (state_reg != ST_READ) begin
            rd_addr_reg    <= '0;
            fetch_done_reg <= 1'b0;
         end
         p_valid_reg <= rd_en;

         // skid / output stages
         if (state_reg != ST_READ || state_next != ST_READ) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
         end else if (load_out) begin
            if (skid_valid_reg) begin
               out_valid_reg  <= 1'b1;
               out_data_reg   <= skid_data_reg;
               out_last_reg   <= skid_last_reg;
               skid_valid_reg <= p_valid_reg;
               skid_data_reg  <= mem_q_reg;
               skid_last_reg  <= p_last_reg;
            end else if (p_valid_reg) begin
               out_valid_reg  <= 1'b1;
               out_data_reg   <= mem_q_reg;
               out_last_reg   <= p_last_reg;
            end else begin
               out_valid_reg  <= 1'b0;
            end
         end else if (p_valid_reg) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= mem_q_reg;
            skid_last_reg  <= p_last_reg;
         end
      end
   end

   assign s_axis_ready = (state_reg == ST_WRITE);
   assign m_axis_valid = out_valid_reg;
   assign m_axis_data  = out_data_reg;
   assign m_axis_last  = out_last_reg;
   assign stored_len   = stored_len_reg;
   assign overflow     = overflow_reg;
   assign state        = state_reg;

endmodule

// File: tb/tb_data_offload_buffer_core.sv
// -----------------------------------------------------------------------------
// tb_data_offload_buffer_core
//
// Self-checking bench: random capture/playback scenarios checked against a
// queue-based model of the captured buffer and the expected beat sequence.
// -----------------------------------------------------------------------------
module tb_data_offload_buffer_core;

   localparam int DW    = 64;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_axis_valid = 1'b0;
   logic          s_axis_ready;
   logic          s_axis_last = 1'b0;
   logic [DW-1:0] s_axis_data = '0;
   logic          m_axis_valid;
   logic          m_axis_ready = 1'b0;
   logic          m_axis_last;
   logic [DW-1:0] m_axis_data;
   logic          init_req = 1'b0;
   logic          sync_ext = 1'b0;
   logic          oneshot = 1'b0;
   logic          sync_mode = 1'b0;
   logic [AW:0]   transfer_length = '0;
   logic [AW:0]   stored_len;
   logic [1:0]    state;
   logic          overflow;

   always #5 clk = ~clk;

   data_offload_buffer_core #(
      .DATA_WIDTH     (DW),
      .MEM_ADDR_WIDTH (AW),
      .HAS_SYNC       (1'b1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_axis_valid    (s_axis_valid),
      .s_axis_ready    (s_axis_ready),
      .s_axis_last     (s_axis_last),
      .s_axis_data     (s_axis_data),
      .m_axis_valid    (m_axis_valid),
      .m_axis_ready    (m_axis_ready),
      .m_axis_last     (m_axis_last),
      .m_axis_data     (m_axis_data),
      .init_req        (init_req),
      .sync_ext        (sync_ext),
      .oneshot         (oneshot),
      .sync_mode       (sync_mode),
      .transfer_length (transfer_length),
      .stored_len      (stored_len),
      .state           (state),
      .overflow        (overflow)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_mem[$];
   int            exp_idx  = 0;
   int            hs_count = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One observed cycle: stall stability, handshake scoreboard, then advance.
   task automatic step();
      if (prev_stall) begin
         check_val("stall_valid", m_axis_valid, 1'b1);
         check_val("stall_data", m_axis_data, prev_data);
         check_val("stall_last", m_axis_last, prev_last);
      end
      if (m_axis_valid && m_axis_ready) begin
         if (exp_mem.size() == 0) begin
            check_val("rd_unexpected", m_axis_valid, 1'b0);
         end else begin
            check_val("rd_data", m_axis_data, exp_mem[exp_idx]);
            check_val("rd_last", m_axis_last, exp_idx == exp_mem.size() - 1);
            exp_idx = (exp_idx + 1) % exp_mem.size();
         end
         hs_count++;
      end
      prev_stall = m_axis_valid && !m_axis_ready;
      prev_data  = m_axis_data;
      prev_last  = m_axis_last;
      tick();
   endtask

   task automatic start_capture(input logic [AW:0] tl, input logic os, input logic sm);
      int guard;
      guard = 0;
      transfer_length = tl;
      oneshot   = os;
      sync_mode = sm;
      init_req  = 1'b1;
      hs_count  = 0;
      while (state != 2'd1 && guard < 50) begin
         m_axis_ready = 1'($urandom_range(0, 1));
         step();
         guard++;
      end
      init_req = 1'b0;
      check_val("enter_write", state, 2'd1);
      check_val("write_no_valid", m_axis_valid, 1'b0);
      check_val("inflight_beats_le1", hs_count <= 1, 1'b1);
   endtask

   // Offers src beats (last on index last_at, -1 = none) until WRITE is left,
   // then checks capture results against the limit/last rules.
   task automatic feed(input logic [DW-1:0] src[$], input int last_at, input int valid_pct);
      int idx, guard, lim, exp_len;
      bit exp_ovf, take;
      idx = 0;
      guard = 0;
      while (state == 2'd1 && guard < 5000) begin
         s_axis_valid = (idx < src.size()) && ($urandom_range(0, 99) < valid_pct);
         s_axis_data  = (idx < src.size()) ? src[idx] : '0;
         s_axis_last  = (idx == last_at);
         take = s_axis_valid && s_axis_ready;
         tick();
         if (take) idx++;
         guard++;
      end
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
      lim = (transfer_length == 0 || transfer_length > DEPTH) ? DEPTH : int'(transfer_length);
      if (last_at >= 0 && last_at + 1 <= lim) begin
         exp_len = last_at + 1;
         exp_ovf = 1'b0;
      end else begin
         exp_len = lim;
         exp_ovf = 1'b1;
      end
      check_val("write_left", state, 2'd2);
      check_val("accepted", idx, exp_len);
      check_val("stored_len", stored_len, exp_len);
      check_val("overflow", overflow, exp_ovf);
      exp_mem.delete();
      for (int i = 0; i < exp_len && i < src.size(); i++) exp_mem.push_back(src[i]);
      exp_idx = 0;
      $display("capture: %0d beats accepted, stored_len=%0d overflow=%0b", idx, stored_len, overflow);
   endtask

   task automatic wait_valid(input int max_cyc);
      int n;
      n = 0;
      m_axis_ready = 1'b0;
      while (!m_axis_valid && n < 20) begin
         step();
         n++;
      end
      check_val("valid_latency_ok", n <= max_cyc, 1'b1);
   endtask

   // mode 0: ready held high, 1: 3-high/2-low, 2: random
   task automatic play(input int n_hs, input int mode, input bit expect_idle);
      int cyc, bubbles;
      bit started;
      cyc = 0;
      bubbles = 0;
      started = 1'b0;
      hs_count = 0;
      while (hs_count < n_hs && cyc < 20 * n_hs + 100) begin
         case (mode)
            0:       m_axis_ready = 1'b1;
            1:       m_axis_ready = (cyc % 5) < 3;
            default: m_axis_ready = 1'($urandom_range(0, 1));
         endcase
         if (started && mode == 0 && !m_axis_valid) bubbles++;
         if (m_axis_valid) started = 1'b1;
         step();
         cyc++;
      end
      check_val("play_count", hs_count, n_hs);
      if (mode == 0) check_val("no_bubbles", bubbles, 0);
      if (expect_idle) begin
         check_val("oneshot_idle", state, 2'd0);
         check_val("oneshot_valid_drop", m_axis_valid, 1'b0);
      end
      m_axis_ready = 1'b0;
      $display("playback: %0d beats in %0d cycles", hs_count, cyc);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] src[$];
      int            n, la, lim, guard;
      logic [AW:0]   tl;
      bit            os;

      // reset values
      repeat (3) tick();
      check_val("rst_state", state, 2'd0);
      check_val("rst_s_ready", s_axis_ready, 1'b0);
      check_val("rst_m_valid", m_axis_valid, 1'b0);
      check_val("rst_m_last", m_axis_last, 1'b0);
      check_val("rst_m_data", m_axis_data, '0);
      check_val("rst_stored_len", stored_len, '0);
      check_val("rst_overflow", overflow, 1'b0);
      rst = 1'b0;
      tick();

      // oneshot capture of 0..15
      src.delete();
      for (int i = 0; i < 16; i++) src.push_back(DW'(i));
      start_capture('0, 1'b1, 1'b0);
      feed(src, 15, 100);
      wait_valid(2);
      play(16, 0, 1'b1);
      check_val("t1_stored_len", stored_len, 16);
      check_val("t1_overflow", overflow, 1'b0);

      // limit 8, 20-beat source without last, cyclic, 3-high/2-low ready
      src.delete();
      for (int i = 0; i < 20; i++) src.push_back({$urandom, $urandom});
      start_capture(11'd8, 1'b0, 1'b0);
      feed(src, -1, 70);
      wait_valid(2);
      play(30, 1, 1'b0);

      // sync gating; an edge during WRITE must be ignored
      src.delete();
      for (int i = 0; i < 4; i++) src.push_back({$urandom, $urandom});
      start_capture('0, 1'b1, 1'b1);
      sync_ext = 1'b1;
      feed(src, 3, 60);
      repeat (100) step();
      check_val("sync_hold_state", state, 2'd2);
      check_val("sync_hold_valid", m_axis_valid, 1'b0);
      sync_ext = 1'b0;
      step();
      sync_ext = 1'b1;
      wait_valid(2);
      sync_ext = 1'b0;
      play(4, 2, 1'b1);

      // re-init mid-pass with the output stalled
      src.delete();
      for (int i = 0; i < 4; i++) src.push_back({$urandom, $urandom});
      start_capture('0, 1'b0, 1'b0);
      feed(src, 3, 100);
      wait_valid(2);
      play(6, 2, 1'b0);
      m_axis_ready = 1'b0;
      guard = 0;
      while (!m_axis_valid && guard < 10) begin
         step();
         guard++;
      end
      hs_count = 0;
      init_req = 1'b1;
      step();
      m_axis_ready = 1'b1;
      step();
      init_req = 1'b0;
      m_axis_ready = 1'b0;
      check_val("reinit_one_beat", hs_count, 1);
      check_val("reinit_state", state, 2'd1);
      check_val("reinit_valid_drop", m_axis_valid, 1'b0);
      src.delete();
      for (int i = 0; i < 6; i++) src.push_back(DW'(8'hAA + i));
      feed(src, 5, 80);
      wait_valid(2);
      play(12, 0, 1'b0);

      // single stored beat, last on every beat
      src.delete();
      for (int i = 0; i < 3; i++) src.push_back({$urandom, $urandom});
      start_capture(11'd1, 1'b0, 1'b0);
      feed(src, -1, 80);
      wait_valid(2);
      play(5, 0, 1'b0);

      // random trials, including limits above the RAM size
      for (int t = 0; t < 6; t++) begin
         n  = $urandom_range(1, 30);
         tl = ($urandom_range(0, 3) == 0) ? 11'd1500 : 11'($urandom_range(0, 32));
         lim = (tl == 0 || tl > DEPTH) ? DEPTH : int'(tl);
         if (lim > n)                      la = n - 1;
         else if ($urandom_range(0, 1) == 1) la = $urandom_range(0, n - 1);
         else                               la = -1;
         os = 1'($urandom_range(0, 1));
         src.delete();
         for (int i = 0; i < n; i++) src.push_back({$urandom, $urandom});
         start_capture(tl, os, 1'b0);
         feed(src, la, 75);
         wait_valid(2);
         play(os ? exp_mem.size() : 2 * exp_mem.size() + 1, 2, os);
      end

      // full depth, wrap without a bubble
      src.delete();
      for (int i = 0; i < DEPTH; i++) src.push_back({$urandom, $urandom});
      start_capture('0, 1'b0, 1'b0);
      feed(src, -1, 100);
      check_val("full_stored_len", stored_len, DEPTH);
      wait_valid(2);
      play(DEPTH + 6, 0, 1'b0);

      // asynchronous reset mid-READ
      play(3, 2, 1'b0);
      m_axis_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check_val("arst_state", state, 2'd0);
      check_val("arst_m_valid", m_axis_valid, 1'b0);
      check_val("arst_m_last", m_axis_last, 1'b0);
      check_val("arst_m_data", m_axis_data, '0);
      check_val("arst_s_ready", s_axis_ready, 1'b0);
      check_val("arst_stored_len", stored_len, '0);
      check_val("arst_overflow", overflow, 1'b0);
      tick();
      rst = 1'b0;
      prev_stall = 1'b0;
      exp_mem.delete();
      tick();
      tick();
      check_val("post_rst_state", state, 2'd0);
      check_val("post_rst_stored_len", stored_len, '0);
      check_val("post_rst_valid", m_axis_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
